// File: rtl/fetch_pair_splitter_pkg.sv
// Shared constants and helpers for the fetch-pair splitter.
package fetch_pair_splitter_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_INST_WIDTH = 32;

  // Queue entry layout: {pc, inst}, pc in the MSBs.
  localparam int INST_LSB = 0;
  localparam int PC_LSB   = DEF_INST_WIDTH;

  localparam logic SLOT0 = 1'b0;
  localparam logic SLOT1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic logic [1:0] slot_onehot(input logic slot);
    return (slot == SLOT1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] mask_popcount(input logic [1:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]};
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_slot_picker.sv
// Lowest-set-bit slot select over a two-slot mask.
module fetch_slot_picker
  import fetch_pair_splitter_pkg::*;
(
  input  logic [1:0] mask_i,
  output logic       slot_o,
  output logic       last_slot_o,
  output logic       any_valid_o
);

  // Slot priority: slot0 first, slot1 only when slot0 is absent.
  always_comb begin
    slot_o = SLOT0;
    case (mask_i)
      2'b01, 2'b11: slot_o = SLOT0;
      2'b10:        slot_o = SLOT1;
      default:      slot_o = SLOT0;
    endcase
    last_slot_o = ^mask_i;
    any_valid_o = |mask_i;
  end

endmodule

// File: rtl/fetch_pair_splitter.sv
// Serialises two-slot fetch packets into single {pc, inst} queue entries.
// Optional macro FETCH_SPLIT_PERF_EN adds stall/drop performance counters.
module fetch_pair_splitter
  import fetch_pair_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INST_WIDTH = DEF_INST_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             resp_valid,
  output logic                             resp_ready,
  input  logic [ADDR_WIDTH-1:0]            resp_pc,
  input  logic [2*INST_WIDTH-1:0]          resp_data,
  input  logic [1:0]                       resp_mask,
  input  logic                             fifo_full,
  output logic                             fifo_write,
  output logic [ADDR_WIDTH+INST_WIDTH-1:0] fifo_indata
`ifdef FETCH_SPLIT_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cnt,
  output logic [31:0]                      perf_drop_cnt
`endif
);

  state_e                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            pc_q, pc_d;
  logic [2*INST_WIDTH-1:0]          data_q, data_d;
  logic [1:0]                       mask_q, mask_d;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] entry_q, entry_d;
  logic                             slot_q, last_q;
  logic                             nxt_slot_s, nxt_last_s, nxt_any_s;
  logic                             hold_s, accept_s, write_s;

  assign hold_s     = (state_q == ST_HOLD);
  assign resp_ready = !hold_s || (!fifo_full && last_q);
  assign accept_s   = resp_valid && resp_ready && !flush;
  assign write_s    = hold_s && !fifo_full && !flush;
  assign fifo_write = write_s;
  assign fifo_indata = entry_q;

  // Slot bookkeeping is done on the next mask so the output entry is ready one edge early.
  fetch_slot_picker u_picker (
    .mask_i      (mask_d),
    .slot_o      (nxt_slot_s),
    .last_slot_o (nxt_last_s),
    .any_valid_o (nxt_any_s)
  );

  // Next held packet: flush discards, accept replaces, write retires one slot.
  always_comb begin
    pc_d   = pc_q;
    data_d = data_q;
    mask_d = mask_q;
    if (flush) begin
      mask_d = 2'b00;
    end else if (accept_s) begin
      pc_d   = resp_pc;
      data_d = resp_data;
      mask_d = resp_mask;
    end else if (write_s) begin
      mask_d = mask_q & ~slot_onehot(slot_q);
    end else begin
      mask_d = mask_q;
    end
  end

  // Next state and pre-formatted queue entry for the next slot to issue.
  always_comb begin
    state_d = nxt_any_s ? ST_HOLD : ST_EMPTY;
    entry_d = {pc_d + {{(ADDR_WIDTH-3){1'b0}}, nxt_slot_s, 2'b00},
               (nxt_slot_s == SLOT1) ? data_d[2*INST_WIDTH-1:INST_WIDTH]
                                     : data_d[INST_WIDTH-1:0]};
  end

  // Packet/state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      pc_q    <= '0;
      data_q  <= '0;
      mask_q  <= 2'b00;
      entry_q <= '0;
      slot_q  <= SLOT0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      entry_q <= entry_d;
      slot_q  <= nxt_slot_s;
      last_q  <= nxt_last_s;
    end
  end

`ifdef FETCH_SPLIT_PERF_EN
  logic [31:0] stall_q, stall_d, drop_q, drop_d;

  // Saturating counters: full-stall cycles and slots thrown away by flush.
  always_comb begin
    stall_d = stall_q;
    drop_d  = drop_q;
    if (hold_s && fifo_full) begin
      stall_d = sat_add32(stall_q, 2'd1);
    end else begin
      stall_d = stall_q;
    end
    if (hold_s && flush) begin
      drop_d = sat_add32(drop_q, mask_popcount(mask_q));
    end else begin
      drop_d = drop_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 32'd0;
      drop_q  <= 32'd0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_drop_cnt  = drop_q;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_pair_splitter.sv
// Scoreboard bench: driver pushes expected entries on acceptance, monitor checks outputs.
module tb_fetch_pair_splitter;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_pc;
  logic [63:0] resp_data;
  logic [1:0]  resp_mask;
  logic        fifo_full;
  logic        fifo_write;
  logic [63:0] fifo_indata;

  logic [63:0] exp_q[$];
  int          total;
  int          bad;

  fetch_pair_splitter dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_pc     (resp_pc),
    .resp_data   (resp_data),
    .resp_mask   (resp_mask),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_indata (fifo_indata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference: an accepted packet becomes its valid slots in ascending order.
  task automatic push_packet(input logic [31:0] pc, input logic [63:0] d, input logic [1:0] m);
    logic [31:0] spc;
    for (int i = 0; i < 2; i++) begin
      if (m[i]) begin
        spc = pc + 32'(4 * i);
        exp_q.push_back({spc, d[32*i +: 32]});
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] d,
                       input logic [1:0] m, input logic full, input logic fl);
    resp_valid = v;
    resp_pc    = pc;
    resp_data  = d;
    resp_mask  = m;
    fifo_full  = full;
    flush      = fl;
    @(posedge clk);
    // Splitter is free exactly when no entry of the held packet is still owed.
    if (reset && v && !fl && exp_q.size() == 0) push_packet(pc, d, m);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 64'd0, 2'b00, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard mid-cycle.
  initial begin
    logic exp_ready;
    logic exp_wr;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_ready", {63'd0, resp_ready}, 64'd1);
        chk("rst_write", {63'd0, fifo_write}, 64'd0);
        chk("rst_indata", fifo_indata, 64'd0);
      end else begin
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && !fifo_full);
        exp_wr    = (exp_q.size() > 0) && !fifo_full && !flush;
        chk("ready", {63'd0, resp_ready}, {63'd0, exp_ready});
        chk("write", {63'd0, fifo_write}, {63'd0, exp_wr});
        if (exp_q.size() > 0) chk("indata", fifo_indata, exp_q[0]);
        if (exp_wr) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    flush = 1'b0;
    resp_valid = 1'b0;
    resp_pc    = 32'd0;
    resp_data  = 64'd0;
    resp_mask  = 2'b00;
    fifo_full  = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(1);

    // Basic pair split.
    drive(1'b1, 32'h1000, {32'h22, 32'h11}, 2'b11, 1'b0, 1'b0);
    idle(3);

    // Back-to-back packets with resp_valid held.
    drive(1'b1, 32'h1000, {32'hB0, 32'hA0}, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 32'h1008, {32'hD0, 32'hC0}, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 32'h1008, {32'hD0, 32'hC0}, 2'b11, 1'b0, 1'b0);
    idle(3);

    // Unaligned entry, then an empty packet.
    drive(1'b1, 32'h2000, {32'h55, 32'h44}, 2'b10, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 32'h2008, {32'h77, 32'h66}, 2'b00, 1'b0, 1'b0);
    idle(2);

    // Queue full for three cycles after the first write.
    drive(1'b1, 32'h4000, {32'h99, 32'h88}, 2'b11, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 64'd0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 64'd0, 2'b00, 1'b1, 1'b0);
    idle(3);

    // Flush in the cycle the first slot would be written.
    drive(1'b1, 32'h5000, {32'hBB, 32'hAA}, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 32'h5008, {32'hDD, 32'hCC}, 2'b11, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, 32'h3000, {32'h31, 32'h30}, 2'b11, 1'b0, 1'b0);
    idle(3);

    // Top-of-address-space packet.
    drive(1'b1, 32'hFFFF_FFF8, {32'hE1, 32'hE0}, 2'b11, 1'b0, 1'b0);
    idle(3);

    // Asynchronous reset between edges while holding a packet.
    drive(1'b1, 32'h6000, {32'hF1, 32'hF0}, 2'b11, 1'b0, 1'b0);
    resp_valid = 1'b0;
    #2;
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("async_rst_write", {63'd0, fifo_write}, 64'd0);
    chk("async_rst_ready", {63'd0, resp_ready}, 64'd1);
    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b1;
    idle(4);

    // Randomised traffic with back-pressure and flushes.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFF8);
      drive($urandom_range(0, 3) != 0, rpc, {$urandom(), $urandom()},
            2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
